// File: rtl/wb_pkg.sv
// Shared Wishbone slave types: FSM state encoding, wait-state counter width, lane-count helper.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } wb_state_t;

  localparam int WS_CNT_W = 4;
  localparam int WS_MAX   = (1 << WS_CNT_W) - 1;

  function automatic int wb_sw(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_ws_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, and it saturates at zero.
// Single-cycle update, no backpressure.
module wb_ws_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wb_mem_slave_ws.sv
// Wishbone classic slave onto a sync SRAM port; 3+WAIT_STATES cycles per transfer, cyc_i drop aborts.
// Optional WB_SLAVE_ERR_EN: zero-select or out-of-depth hits end with a one-cycle err_o instead of ack_o.
module wb_mem_slave_ws
  import wb_pkg::*;
#(
  parameter int                   DW          = 8,
  parameter int                   AW          = 16,
  parameter int                   MEM_AW      = 12,
  parameter logic [AW-MEM_AW-1:0] BASE        = '0,
  parameter int                   MEM_DEPTH   = 4096,
  parameter int                   WAIT_STATES = 0,
  localparam int                  SW          = wb_sw(DW)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AW-1:0]     adr_i,
  input  logic [DW-1:0]     dat_i,
  input  logic [SW-1:0]     sel_i,
  input  logic              we_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  output logic [DW-1:0]     dat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [SW-1:0]     mem_be,
  output logic [MEM_AW-1:0] mem_dir,
  output logic [DW-1:0]     mem_indata,
  input  logic [DW-1:0]     mem_outdata
);

  if (WAIT_STATES < 0 || WAIT_STATES > WS_MAX) begin : g_ws_check
    $fatal(1, "wb_mem_slave_ws: WAIT_STATES must be 0..15");
  end
  if (MEM_DEPTH > (1 << MEM_AW)) begin : g_depth_check
    $fatal(1, "wb_mem_slave_ws: MEM_DEPTH exceeds 2**MEM_AW");
  end

  wb_state_t r_state, w_next;

  logic [MEM_AW-1:0] r_adr;
  logic [DW-1:0]     r_wdat;
  logic [SW-1:0]     r_sel;
  logic              r_we;
  logic [DW-1:0]     r_rdat;

  logic w_hit;
  logic w_err_req;
  logic w_start;
  logic w_dec;
  logic w_zero;
  logic w_capture;

  assign w_hit = cyc_i & stb_i & (adr_i[AW-1:MEM_AW] == BASE);

`ifdef WB_SLAVE_ERR_EN
  assign w_err_req = (sel_i == '0) || (32'(adr_i[MEM_AW-1:0]) >= 32'(MEM_DEPTH));
`else
  assign w_err_req = 1'b0;
`endif

  assign w_start   = (r_state == ST_IDLE) & w_hit & ~w_err_req;
  assign w_dec     = (r_state == ST_MEM) & cyc_i;
  // Read data is taken on the last memory cycle only, and only if the master is still there.
  assign w_capture = (r_state == ST_MEM) & cyc_i & w_zero & ~r_we;

  wb_ws_counter #(
    .W (WS_CNT_W)
  ) u_ws_cnt (
    .i_clk      (clk_i),
    .i_rst_n    (rst_i),
    .i_load     (w_start),
    .i_load_val (WS_CNT_W'(WAIT_STATES)),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ack_o  = 1'b0;
    err_o  = 1'b0;
    mem_cs = 1'b0;
    mem_we = 1'b0;
    mem_oe = 1'b0;
    mem_be = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_next = w_err_req ? ST_ERR : ST_MEM;
        end
      end
      ST_MEM: begin
        mem_cs = 1'b1;
        mem_we = r_we;
        mem_oe = ~r_we;
        mem_be = r_sel;
        if (!cyc_i) begin
          w_next = ST_IDLE;
        end else if (w_zero) begin
          w_next = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_o  = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERR: begin
`ifdef WB_SLAVE_ERR_EN
        err_o  = 1'b1;
`endif
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_adr  <= '0;
      r_wdat <= '0;
      r_sel  <= '0;
      r_we   <= 1'b0;
      r_rdat <= '0;
    end else begin
      if (w_start) begin
        r_adr  <= adr_i[MEM_AW-1:0];
        r_wdat <= dat_i;
        r_sel  <= sel_i;
        r_we   <= we_i;
      end
      if (w_capture) begin
        r_rdat <= mem_outdata;
      end
    end
  end

  assign dat_o      = r_rdat;
  assign mem_dir    = r_adr;
  assign mem_indata = r_wdat;

endmodule

// File: tb/tb_wb_mem_slave_ws.sv
// Bench for wb_mem_slave_ws: a 32-bit/3-wait-state instance and an 8-bit/0-wait-state instance,
// each with a behavioural SRAM, plus a transaction-level reference memory for random traffic.
module tb_wb_mem_slave_ws;

  localparam int WS32  = 3;
  localparam int LAT32 = WS32 + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_req = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] adr32;
  logic [31:0] wdat32, rdat32, mind32, mout32;
  logic [3:0]  sel32, be32;
  logic        we32, stb32, cyc32, ack32, err32, cs32, mwe32, moe32;
  logic [11:0] mdir32;

  logic [15:0] adr8;
  logic [7:0]  wdat8, rdat8, mind8, mout8;
  logic [0:0]  sel8, be8;
  logic        we8, stb8, cyc8, ack8, err8, cs8, mwe8, moe8;
  logic [11:0] mdir8;

  wb_mem_slave_ws #(
    .DW(32), .AW(16), .MEM_AW(12), .BASE(4'h0), .MEM_DEPTH(1024), .WAIT_STATES(WS32)
  ) u_dut32 (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr32), .dat_i(wdat32), .sel_i(sel32),
    .we_i(we32), .stb_i(stb32), .cyc_i(cyc32), .dat_o(rdat32), .ack_o(ack32),
    .err_o(err32), .mem_cs(cs32), .mem_we(mwe32), .mem_oe(moe32), .mem_be(be32),
    .mem_dir(mdir32), .mem_indata(mind32), .mem_outdata(mout32)
  );

  wb_mem_slave_ws #(
    .DW(8), .AW(16), .MEM_AW(12), .BASE(4'h0), .MEM_DEPTH(4096), .WAIT_STATES(0)
  ) u_dut8 (
    .clk_i(clk), .rst_i(rst_n), .adr_i(adr8), .dat_i(wdat8), .sel_i(sel8),
    .we_i(we8), .stb_i(stb8), .cyc_i(cyc8), .dat_o(rdat8), .ack_o(ack8),
    .err_o(err8), .mem_cs(cs8), .mem_we(mwe8), .mem_oe(moe8), .mem_be(be8),
    .mem_dir(mdir8), .mem_indata(mind8), .mem_outdata(mout8)
  );

  function automatic logic [31:0] init32(input int i);
    logic [15:0] a;
    a = i[15:0];
    return {a, ~a};
  endfunction

  function automatic logic [7:0] init8(input int i);
    return (i == 18) ? 8'hA5 : i[7:0];
  endfunction

  logic [31:0] sram32 [0:4095];
  logic [7:0]  sram8  [0:4095];
  logic [31:0] ref32  [0:4095];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 4096; i++) sram32[i] <= init32(i);
    end else if (cs32 && mwe32) begin
      for (int b = 0; b < 4; b++)
        if (be32[b]) sram32[mdir32][8*b +: 8] <= mind32[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 4096; i++) sram8[i] <= init8(i);
    end else if (cs8 && mwe8 && be8[0]) begin
      sram8[mdir8] <= mind8;
    end
  end

  assign mout32 = moe32 ? sram32[mdir32] : 32'h0;
  assign mout8  = moe8  ? sram8[mdir8]   : 8'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref32[a[11:0]][8*b +: 8] = d[8*b +: 8];
  endtask

  // One classic transfer; stops at ack/err or after 20 cycles, then releases the bus.
  task automatic xfer32(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic got_ack, output logic got_err,
                        output int lat, output int cs_n, output logic [31:0] rd);
    got_ack = 1'b0; got_err = 1'b0; lat = 21; cs_n = 0; rd = '0;
    @(negedge clk);
    we32 = we; adr32 = a; wdat32 = d; sel32 = s; cyc32 = 1'b1; stb32 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cs32) cs_n++;
      if (ack32 || err32) begin
        got_ack = ack32; got_err = err32; lat = i; rd = rdat32;
        break;
      end
    end
    cyc32 = 1'b0; stb32 = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic        ga, ge;
    int          lat, csn, n;
    logic [31:0] rd, last_rd;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        w, miss;

    tbl[0] = '{1'b1, 16'h0010, 32'h11223344, 4'hF, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 16'h0010, 32'h0,        4'hF, 1'b1, 32'h11223344};
    tbl[2] = '{1'b1, 16'h0010, 32'hAABBCCDD, 4'hA, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 16'h0010, 32'h0,        4'hF, 1'b1, 32'hAA22CC44};
    tbl[4] = '{1'b1, 16'h0100, 32'hDEADBEEF, 4'h5, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 16'h0100, 32'h0,        4'hF, 1'b1, 32'h01ADFEEF};
    tbl[6] = '{1'b0, 16'h1234, 32'h0,        4'hF, 1'b0, 32'h0};
    tbl[7] = '{1'b1, 16'h03FF, 32'h77000000, 4'h8, 1'b1, 32'h0};
    tbl[8] = '{1'b0, 16'h03FF, 32'h0,        4'hF, 1'b1, 32'h77FFFC00};
    tbl[9] = '{1'b1, 16'h1234, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};

    adr32 = '0; wdat32 = '0; sel32 = '0; we32 = 1'b0; stb32 = 1'b0; cyc32 = 1'b0;
    adr8 = '0; wdat8 = '0; sel8 = '0; we8 = 1'b0; stb8 = 1'b0; cyc8 = 1'b0;
    for (int i = 0; i < 4096; i++) ref32[i] = init32(i);

    #1 rst_n = 1'b0;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    chk("rst_ctrl32", {ack32, err32, cs32, mwe32, moe32, be32}, 0);
    chk("rst_data32", {mdir32, rdat32}, 0);
    chk("rst_wdat32", mind32, 0);
    chk("rst_all8", {ack8, err8, cs8, mwe8, moe8, be8, mdir8, rdat8, mind8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-bit, zero wait states: one memory cycle then ack with the memory byte.
    adr8 = 16'h0012; we8 = 1'b0; sel8 = 1'b1; cyc8 = 1'b1; stb8 = 1'b1;
    @(negedge clk);
    chk("t2_mem_cycle", {cs8, moe8, ack8, mdir8}, {3'b110, 12'h012});
    @(negedge clk);
    chk("t2_ack_cycle", {cs8, ack8, err8}, 3'b010);
    chk("t2_rdata", rdat8, 8'hA5);
    cyc8 = 1'b0; stb8 = 1'b0;
    @(negedge clk);
    chk("t2_ack_single", ack8, 0);

    last_rd = '0;
    for (int t = 0; t < 10; t++) begin
      xfer32(tbl[t].we, tbl[t].adr, tbl[t].dat, tbl[t].sel, ga, ge, lat, csn, rd);
      if (tbl[t].hit) begin
        chk($sformatf("tbl%0d_lat", t), lat, LAT32);
        chk($sformatf("tbl%0d_cs_cycles", t), csn, WS32 + 1);
        if (tbl[t].we) begin
          chk($sformatf("tbl%0d_hold", t), rd, last_rd);
          ref_write(tbl[t].adr, tbl[t].dat, tbl[t].sel);
        end else begin
          chk($sformatf("tbl%0d_rdata", t), rd, tbl[t].exp_rd);
          last_rd = tbl[t].exp_rd;
        end
      end else begin
        chk($sformatf("tbl%0d_miss", t), {ga, ge, 8'(csn)}, 0);
      end
    end
    chk("t3_mem_word", sram32[12'h100], 32'h01ADFEEF);

    for (int r = 0; r < 40; r++) begin
      w = 1'($urandom_range(1));
      miss = ($urandom_range(7) == 0);
      a = miss ? {4'(1 + $urandom_range(14)), 12'($urandom)} : {6'b0, 10'($urandom)};
      d = $urandom;
      s = 4'(1 + $urandom_range(14));
      xfer32(w, a, d, s, ga, ge, lat, csn, rd);
      if (miss) begin
        chk($sformatf("rnd%0d_miss", r), {ga, ge, 8'(csn)}, 0);
      end else begin
        chk($sformatf("rnd%0d_lat", r), {ga, ge, 8'(lat)}, {2'b10, 8'(LAT32)});
        if (w) begin
          chk($sformatf("rnd%0d_hold", r), rd, last_rd);
          ref_write(a, d, s);
        end else begin
          chk($sformatf("rnd%0d_rdata", r), rd, ref32[a[11:0]]);
          last_rd = ref32[a[11:0]];
        end
      end
    end

    // Address beyond MEM_DEPTH.
    xfer32(1'b0, 16'h0400, 32'h0, 4'hF, ga, ge, lat, csn, rd);
`ifdef WB_SLAVE_ERR_EN
    chk("t6_err", {ga, ge, 8'(lat), 8'(csn)}, {2'b01, 8'd1, 8'd0});
`else
    chk("t6_ack", {ga, ge, 8'(lat), 8'(csn)}, {2'b10, 8'(LAT32), 8'(WS32 + 1)});
    chk("t6_rdata", rd, ref32[12'h400]);
`endif

    // Held strobe: the second ack needs a fresh IDLE sample.
    @(negedge clk);
    we32 = 1'b0; adr32 = 16'h0010; sel32 = 4'hF; cyc32 = 1'b1; stb32 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack32 && n < 20);
    chk("b2b_first_lat", n, LAT32);
    chk("b2b_first_data", rdat32, ref32[12'h010]);
    @(negedge clk);
    chk("b2b_single_pulse", ack32, 0);
    n = 1;
    while (!ack32 && n < 20) begin @(negedge clk); n++; end
    chk("b2b_gap", n, LAT32 + 1);
    cyc32 = 1'b0; stb32 = 1'b0;

    // Abort in the second memory cycle.
    @(negedge clk);
    we32 = 1'b0; adr32 = 16'h0200; sel32 = 4'hF; cyc32 = 1'b1; stb32 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_cs", cs32, 1);
    cyc32 = 1'b0; stb32 = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack32 || cs32 || err32) n++;
    end
    chk("abort_quiet", n, 0);
    xfer32(1'b0, 16'h0200, 32'h0, 4'hF, ga, ge, lat, csn, rd);
    chk("abort_next_read", {ga, ge, 8'(lat)}, {2'b10, 8'(LAT32)});
    chk("abort_next_data", rd, ref32[12'h200]);

    // Reset asserted between clock edges during MEM.
    @(negedge clk);
    we32 = 1'b1; adr32 = 16'h0020; wdat32 = 32'h12345678; sel32 = 4'hF; cyc32 = 1'b1; stb32 = 1'b1;
    @(negedge clk);
    chk("midrst_pre", {cs32, mwe32, mdir32}, {2'b11, 12'h020});
    cyc32 = 1'b0; stb32 = 1'b0; we32 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {ack32, err32, cs32, mwe32, moe32, be32}, 0);
    chk("midrst_data", {mdir32, rdat32}, 0);
    chk("midrst_wdat", mind32, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_write(16'h0020, 32'h12345678, 4'hF);
    xfer32(1'b0, 16'h0010, 32'h0, 4'hF, ga, ge, lat, csn, rd);
    chk("postrst_read", {ga, ge, 8'(lat)}, {2'b10, 8'(LAT32)});
    chk("postrst_data", rd, ref32[12'h010]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
